// File: rtl/raycast_column_store_if.sv
// Producer, frame-control and renderer signals of the ping-pong column store.
// The bench drives the master side and the store takes the slave side.
interface raycast_column_store_if #(
    parameter int unsigned H_W = 10,
    parameter int unsigned X_W = 10
) ();
    logic           i_col_valid;
    logic [X_W-1:0] i_col_x;
    logic [H_W-1:0] i_col_height;
    logic           o_col_ready;
    logic           i_frame_done;
    logic           i_vsync;
    logic [X_W-1:0] i_rd_x;
    logic [H_W-1:0] o_rd_height;
    logic           o_front_sel;
    logic           o_swap;
    logic           o_frame_drop;

    modport master (
        output i_col_valid, i_col_x, i_col_height, i_frame_done, i_vsync, i_rd_x,
        input  o_col_ready, o_rd_height, o_front_sel, o_swap, o_frame_drop
    );

    modport slave (
        input  i_col_valid, i_col_x, i_col_height, i_frame_done, i_vsync, i_rd_x,
        output o_col_ready, o_rd_height, o_front_sel, o_swap, o_frame_drop
    );
endinterface

// File: rtl/raycast_column_store.sv
// Ping-pong column-height store: the raycaster fills the back bank while the renderer
// reads the front bank. Banks swap at vsync, and only after a full back frame is done.
module raycast_column_store #(
    parameter int unsigned NUM_COLS = 640,
    parameter int unsigned H_W      = 10,
    parameter int unsigned X_W      = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    raycast_column_store_if.slave  bus
);
    localparam logic [X_W:0] ColLimit = (X_W + 1)'(NUM_COLS);

    typedef enum logic [0:0] {StFill, StPending} state_e;

    state_e         state_q, state_d;
    logic           col_ready;
    logic           front_sel_q;
    logic           swap_q;
    logic           drop_q;
    logic [H_W-1:0] rd_height_q;

    logic [H_W-1:0] bank0 [NUM_COLS];
    logic [H_W-1:0] bank1 [NUM_COLS];

    logic wr_in_range, rd_in_range, wr_en, swap_event, drop_event;

    assign wr_in_range = {1'b0, bus.i_col_x} < ColLimit;
    assign rd_in_range = {1'b0, bus.i_rd_x} < ColLimit;
    // Out-of-range writes still handshake but never reach a bank.
    assign wr_en       = bus.i_col_valid & col_ready & wr_in_range;
    assign swap_event  = (state_q == StPending) & bus.i_vsync;
    assign drop_event  = (state_q == StPending) & bus.i_frame_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:    if (bus.i_frame_done) state_d = StPending;
            StPending: if (bus.i_vsync)      state_d = StFill;
            default:                         state_d = StFill;
        endcase
    end

    always_comb begin
        col_ready = (state_q == StFill);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            front_sel_q <= 1'b0;
            swap_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            if (swap_event) front_sel_q <= ~front_sel_q;
            swap_q <= swap_event;
            drop_q <= drop_event;
        end
    end

    // Back bank is always the one not being displayed.
    always_ff @(posedge i_clk) begin
        if (wr_en && front_sel_q)  bank0[bus.i_col_x] <= bus.i_col_height;
        if (wr_en && !front_sel_q) bank1[bus.i_col_x] <= bus.i_col_height;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_height_q <= '0;
        end else if (!rd_in_range) begin
            rd_height_q <= '0;
        end else if (front_sel_q) begin
            rd_height_q <= bank1[bus.i_rd_x];
        end else begin
            rd_height_q <= bank0[bus.i_rd_x];
        end
    end

    assign bus.o_col_ready  = col_ready;
    assign bus.o_rd_height  = rd_height_q;
    assign bus.o_front_sel  = front_sel_q;
    assign bus.o_swap       = swap_q;
    assign bus.o_frame_drop = drop_q;
endmodule

// File: tb/tb_raycast_column_store.sv
// Bench for raycast_column_store: directed frame/swap sequences, a read vector table,
// and randomized traffic against an array-based model of the two banks.
module tb_raycast_column_store;
    localparam int NCOL = 640;

    logic i_clk;
    logic i_rst_n;

    raycast_column_store_if #(.H_W(10), .X_W(10)) bus ();

    raycast_column_store #(.NUM_COLS(640), .H_W(10), .X_W(10)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total;
    int bad;

    // Model: bank contents, which entries hold defined data, displayed bank, pending flag.
    int mem   [2][NCOL];
    bit known [2][NCOL];
    bit m_front;
    bit m_pending;

    typedef struct {
        int rd_x;
        int height;
    } rd_vec_t;

    rd_vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.i_col_valid  = 1'b0;
        bus.i_col_x      = '0;
        bus.i_col_height = '0;
        bus.i_frame_done = 1'b0;
        bus.i_vsync      = 1'b0;
    endtask

    // Advance one clock with the current inputs and compare every output to the model.
    task automatic cycle();
        int  x, rx, exp_rd;
        bit  rd_known, exp_swap, exp_drop;
        x  = int'(bus.i_col_x);
        rx = int'(bus.i_rd_x);
        if (rx < NCOL) begin
            rd_known = known[m_front][rx];
            exp_rd   = mem[m_front][rx];
        end else begin
            rd_known = 1'b1;
            exp_rd   = 0;
        end
        exp_swap = m_pending && bus.i_vsync;
        exp_drop = m_pending && bus.i_frame_done;
        if (!m_pending) begin
            if (bus.i_col_valid && x < NCOL) begin
                mem[!m_front][x]   = int'(bus.i_col_height);
                known[!m_front][x] = 1'b1;
            end
            if (bus.i_frame_done) m_pending = 1'b1;
        end else if (bus.i_vsync) begin
            m_front   = !m_front;
            m_pending = 1'b0;
        end
        @(posedge i_clk);
        #1;
        if (rd_known) check("model_rd_height", int'(bus.o_rd_height), exp_rd);
        check("model_swap", int'(bus.o_swap), int'(exp_swap));
        check("model_drop", int'(bus.o_frame_drop), int'(exp_drop));
        check("model_front_sel", int'(bus.o_front_sel), int'(m_front));
        check("model_col_ready", int'(bus.o_col_ready), int'(!m_pending));
    endtask

    task automatic write_col(input int x, input int h);
        bus.i_col_valid  = 1'b1;
        bus.i_col_x      = 10'(x);
        bus.i_col_height = 10'(h);
        cycle();
        bus.i_col_valid  = 1'b0;
    endtask

    task automatic pulse(input bit done, input bit vs);
        bus.i_frame_done = done;
        bus.i_vsync      = vs;
        cycle();
        bus.i_frame_done = 1'b0;
        bus.i_vsync      = 1'b0;
    endtask

    task automatic read_chk(input string name, input int x, input int exp);
        bus.i_rd_x = 10'(x);
        cycle();
        check(name, int'(bus.o_rd_height), exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NCOL; c++) begin
                mem[b][c]   = 0;
                known[b][c] = 1'b0;
            end
        end
        m_front   = 1'b0;
        m_pending = 1'b0;

        vecs[0] = '{rd_x: 0,    height: 0};
        vecs[1] = '{rd_x: 5,    height: 5};
        vecs[2] = '{rd_x: 320,  height: 320};
        vecs[3] = '{rd_x: 639,  height: 639};
        vecs[4] = '{rd_x: 640,  height: 0};
        vecs[5] = '{rd_x: 700,  height: 0};
        vecs[6] = '{rd_x: 1023, height: 0};

        idle();
        bus.i_rd_x = '0;
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_rd_height", int'(bus.o_rd_height), 0);
        check("reset_front_sel", int'(bus.o_front_sel), 0);
        check("reset_swap", int'(bus.o_swap), 0);
        check("reset_drop", int'(bus.o_frame_drop), 0);
        check("reset_col_ready", int'(bus.o_col_ready), 1);
        #2;
        i_rst_n = 1'b1;

        // Frame 1: height = x, then done and vsync.
        for (int x = 0; x < NCOL; x++) write_col(x, x);
        pulse(1'b1, 1'b0);
        check("f1_ready_pending", int'(bus.o_col_ready), 0);
        pulse(1'b0, 1'b1);
        check("f1_swap", int'(bus.o_swap), 1);
        check("f1_front_sel", int'(bus.o_front_sel), 1);
        cycle();
        check("f1_swap_one_cycle", int'(bus.o_swap), 0);

        for (int i = 0; i < 7; i++) begin
            read_chk($sformatf("vec_rd_x%0d", vecs[i].rd_x), vecs[i].rd_x, vecs[i].height);
        end

        // Frame 2: height = 639 - x.
        for (int x = 0; x < NCOL; x++) write_col(x, 639 - x);
        pulse(1'b1, 1'b0);
        read_chk("f2_pre_vsync_rd5", 5, 5);
        check("f2_pre_vsync_ready", int'(bus.o_col_ready), 0);
        // A read in the swap cycle still sees the old front bank.
        bus.i_rd_x = 10'd5;
        pulse(1'b0, 1'b1);
        check("f2_swap_cycle_rd5", int'(bus.o_rd_height), 5);
        check("f2_front_sel", int'(bus.o_front_sel), 0);
        read_chk("f2_post_rd5", 5, 634);

        // Partial frame then vsync in FILL: frame repeat.
        for (int x = 0; x < 100; x++) write_col(x, 500 + x);
        pulse(1'b0, 1'b1);
        check("repeat_no_swap", int'(bus.o_swap), 0);
        check("repeat_front_sel", int'(bus.o_front_sel), 0);
        check("repeat_ready", int'(bus.o_col_ready), 1);
        read_chk("repeat_rd5", 5, 634);

        // done and vsync together: pending, swap waits for the next vsync.
        pulse(1'b1, 1'b1);
        check("same_cyc_no_swap", int'(bus.o_swap), 0);
        check("same_cyc_ready", int'(bus.o_col_ready), 0);
        pulse(1'b1, 1'b0);
        check("drop_pulse", int'(bus.o_frame_drop), 1);
        cycle();
        check("drop_one_cycle", int'(bus.o_frame_drop), 0);
        write_col(3, 99);
        check("pending_ready", int'(bus.o_col_ready), 0);
        pulse(1'b0, 1'b1);
        check("pending_swap", int'(bus.o_swap), 1);
        check("pending_front_sel", int'(bus.o_front_sel), 1);
        read_chk("blocked_write_x3", 3, 503);
        read_chk("partial_x5", 5, 505);
        read_chk("leftover_x200", 200, 200);

        // Asynchronous reset mid-fill.
        for (int x = 0; x < 10; x++) write_col(x, 900 + x);
        bus.i_rd_x = 10'd5;
        cycle();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_front_sel", int'(bus.o_front_sel), 0);
        check("async_rst_rd_height", int'(bus.o_rd_height), 0);
        check("async_rst_ready", int'(bus.o_col_ready), 1);
        check("async_rst_swap", int'(bus.o_swap), 0);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        m_front   = 1'b0;
        m_pending = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bus.i_col_valid  = ($urandom_range(0, 3) != 0);
            bus.i_col_x      = 10'($urandom_range(0, 700));
            bus.i_col_height = 10'($urandom_range(0, 1023));
            bus.i_frame_done = ($urandom_range(0, 199) == 0);
            bus.i_vsync      = ($urandom_range(0, 99) == 0);
            bus.i_rd_x       = 10'($urandom_range(0, 1023));
            cycle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
